data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter ADDRESS_WIDTH, default 12, byte-address bits decoded; storage is 2**ADDRESS_WIDTH bytes.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted between accept and response; legal range 0..15.
REQ-004 The module SHALL have one clock, clk (input, 1 bit), on whose rising edge all state updates occur.
REQ-005 The module SHALL have an asynchronous, active-low reset, rst_n (input, 1 bit).
REQ-006 Ports:
  req_valid  in  1  initiator presents a request
  req_ready  out 1  responder can accept a request
  req_we     in  1  1 = store, 0 = load
  req_size   in  2  00 byte, 01 half, 10 word, 11 treated as word
  req_unsigned in 1 load zero-extends when 1, sign-extends when 0
  req_addr   in  32 byte address
  req_wdata  in  32 store data, right-aligned
  rsp_valid  out 1  response available
  rsp_ready  in  1  initiator takes the response
  rsp_rdata  out 32 load result, extended
  rsp_err    out 1  misaligned-access error

Function
REQ-007 FSM states: IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 IDLE: on req_valid && req_ready, latch we/size/unsigned/addr/wdata; go to BUSY if WAIT_CYCLES>0, else RESP.
REQ-009 BUSY: count down from WAIT_CYCLES-1 to 0; at 0 go to RESP.
REQ-010 Total latency: rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-011 Stores SHALL commit to storage on the edge entering RESP, writing only the addressed byte lanes.
REQ-012 Loads SHALL read storage on the edge entering RESP; rsp_rdata = selected lanes shifted to bit 0 and extended per req_unsigned; stores return rsp_rdata = 0.
REQ-013 RESP: rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_valid && rsp_ready; that edge returns to IDLE and clears rsp_valid.
REQ-014 A new request SHALL NOT be accepted on the same edge a response is consumed (one outstanding transaction, no bypass).
REQ-015 Address bits above ADDRESS_WIDTH-1 SHALL be ignored (storage wraps).
REQ-016 req_* inputs changing while not in IDLE SHALL have no effect.

Reset
REQ-017 rst_n low SHALL force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 immediately; storage contents are not reset.
REQ-018 Reset during BUSY SHALL discard the pending transaction; an uncommitted store never writes.

Configuration
REQ-019 Macro DMEM_MISALIGN_ERR_EN defined: half at addr[0]=1 or word at addr[1:0]!=00 SHALL not access storage, SHALL respond with rsp_err=1, rsp_rdata=0, same latency.
REQ-020 Macro undefined: rsp_err SHALL be constant 0; half ignores addr[0], word ignores addr[1:0] (forced alignment).

Structure
REQ-021 Package mem_pkg SHALL hold the access-size enum, the FSM state enum and the wait-counter width constant.
REQ-022 Sub-module dmem_load_ext SHALL perform combinational lane selection and sign/zero extension.

Verification
REQ-023 WAIT_CYCLES=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF.
REQ-024 After REQ-023: load byte signed @0x13 -> 0xFFFFFFDE; load half unsigned @0x10 -> 0x0000BEEF; store byte 0x55 @0x11 then load word @0x10 -> 0xDEAD55EF.
REQ-025 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready 0, second req_valid ignored until handshake.
REQ-026 rst_n pulsed low one cycle after accepting a store 0x12345678 @0x20 -> outputs zero at once, subsequent load @0x20 returns prior content.
REQ-027 With DMEM_MISALIGN_ERR_EN: store word @0x22 -> rsp_err=1, storage unchanged; without it: same store writes word @0x20, rsp_err=0.
REQ-028 WAIT_CYCLES=0: load accepted -> rsp_valid on next edge; address 0x1010 with ADDRESS_WIDTH=12 aliases 0x010.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access sizes, responder FSM states and wait-counter width
package mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_WORD2 = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: selects load byte lanes, shifts them to bit 0 and sign/zero extends
module dmem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = word >> {off, 3'b000};
  assign data = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
                size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated byte-addressable data memory with valid/ready request and response
// DMEM_MISALIGN_ERR_EN: misaligned half/word accesses respond with rsp_err instead of forced alignment
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int AW = ADDRESS_WIDTH;
  state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic l_we, l_uns, c_we, c_uns;
  size_e l_size, c_size;
  logic [AW-1:0] l_addr, c_addr;
  logic [DATA_WIDTH-1:0] l_wdata, c_wdata, wdata_sh, ld_data;
  logic idle, enter, mis, wide, half;
  logic [1:0] off;
  logic [3:0] be;
  logic [31:0] mem [2**(AW-2)];
  logic unused;
  assign unused = ^req_addr[31:AW];
  assign idle = state == IDLE;
  assign req_ready = idle;
  // While idle the live request is the access; afterwards the latched copy is
  assign c_we = idle ? req_we : l_we;
  assign c_uns = idle ? req_unsigned : l_uns;
  assign c_size = idle ? size_e'(req_size) : l_size;
  assign c_addr = idle ? req_addr[AW-1:0] : l_addr;
  assign c_wdata = idle ? req_wdata : l_wdata;
  assign wide = c_size[1];
  assign half = c_size == SZ_HALF;
`ifdef DMEM_MISALIGN_ERR_EN
  assign mis = (half & c_addr[0]) | (wide & |c_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign off = wide ? 2'b00 : half ? {c_addr[1], 1'b0} : c_addr[1:0];
  assign be = wide ? 4'hF : (half ? 4'h3 : 4'h1) << off;
  assign wdata_sh = c_wdata << {off, 3'b000};
  assign enter = state_nx == RESP && state != RESP;
  dmem_load_ext u_ext (
    .word(mem[c_addr[AW-1:2]]),
    .off (off),
    .size(c_size),
    .uns (c_uns),
    .data(ld_data)
  );
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (idle) begin
      if (req_valid) begin
        state_nx = WAIT_CYCLES == 0 ? RESP : BUSY;
        cnt_nx = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
      end
    end else if (state == BUSY) begin
      state_nx = cnt == '0 ? RESP : BUSY;
      cnt_nx = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (rsp_ready) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_uns <= 1'b0;
      l_size <= SZ_BYTE;
      l_addr <= '0;
      l_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (idle && req_valid) begin
        l_we <= req_we;
        l_uns <= req_unsigned;
        l_size <= size_e'(req_size);
        l_addr <= req_addr[AW-1:0];
        l_wdata <= req_wdata;
      end
      if (enter) begin
        rsp_valid <= 1'b1;
        rsp_err <= mis;
        rsp_rdata <= (c_we | mis) ? '0 : ld_data;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
  // Storage is never reset; rst_n gating keeps an aborted store from landing
  always_ff @(posedge clk)
    if (rst_n && enter && c_we && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[c_addr[AW-1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and 0 instances)
module tb_data_mem_responder;
  typedef struct {logic [31:0] d; logic e;} exp_t;
  logic clk = 0, rst_n = 0, sel = 0;
  logic req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic rdy, rv, re;
  logic [31:0] rd;
  logic [7:0] m [0:1][0:4095];
  exp_t q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign rdy = sel ? b_req_ready : a_req_ready;
  assign rv = sel ? b_rsp_valid : a_rsp_valid;
  assign rd = sel ? b_rsp_rdata : a_rsp_rdata;
  assign re = sel ? b_rsp_err : a_rsp_err;
  data_mem_responder #(.WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));
  data_mem_responder #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  // Reference model: byte-wise storage, expectation pushed when the request is driven
  task automatic push_exp(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] ad, input logic [31:0] wd);
    exp_t x;
    int n;
    logic [11:0] a, base;
    logic mis;
    logic [31:0] v;
    a = ad[11:0];
    n = sz[1] ? 4 : (sz == 2'b01) ? 2 : 1;
`ifdef DMEM_MISALIGN_ERR_EN
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    base = sz[1] ? {a[11:2], 2'b00} : (sz == 2'b01) ? {a[11:1], 1'b0} : a;
    v = 0;
    if (!mis)
      for (int i = 0; i < n; i++)
        if (we) m[sel][32'(base) + i] = wd[8*i +: 8];
        else v[8*i +: 8] = m[sel][32'(base) + i];
    if (!we && !un && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!we && !un && n == 2) v = {{16{v[15]}}, v[15:0]};
    x.d = v;
    x.e = mis;
    q.push_back(x);
  endtask

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] ad, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd; req_valid = 1;
  endtask

  task automatic scramble;
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom); req_size = 2'($urandom);
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] ad, input logic [31:0] wd, output logic [31:0] got);
    exp_t x;
    int n, lat;
    push_exp(we, sz, un, ad, wd);
    drive_req(we, sz, un, ad, wd);
    rsp_ready = 1;
    n = 0;
    while (!rdy && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL accept_timeout addr=%h got req_ready=%b want 1", ad, rdy);
      x = q.pop_front();
      got = 0;
      scramble();
      return;
    end
    @(posedge clk); #1;
    scramble();
    lat = 1;
    while (!rv && lat < 40) begin @(posedge clk); #1; lat++; end
    x = q.pop_front();
    total++;
    if (lat !== (sel ? 1 : 3)) begin bad++; $display("FAIL latency addr=%h got %0d want %0d", ad, lat, sel ? 1 : 3); end
    total++;
    if (rd !== x.d) begin bad++; $display("FAIL rdata addr=%h got %h want %h", ad, rd, x.d); end
    total++;
    if (re !== x.e) begin bad++; $display("FAIL rsp_err addr=%h got %b want %b", ad, re, x.e); end
    got = rd;
    @(posedge clk); #1;
    total++;
    if (rv !== 1'b0) begin bad++; $display("FAIL rsp_clear addr=%h got %b want 0", ad, rv); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    total += 5;
    if (a_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", a_req_ready); end
    if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", a_rsp_valid); end
    if (a_rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got %h want 0", a_rsp_rdata); end
    if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got %b want 0", a_rsp_err); end
    if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_b_rsp_valid got %b want 0", b_rsp_valid); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] g;
    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, g);
    xact(0, 2'b10, 0, 32'h10, 0, g);
    total++; if (g !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_10 got %h want deadbeef", g); end
    xact(0, 2'b00, 0, 32'h13, 0, g);
    total++; if (g !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb_13 got %h want ffffffde", g); end
    xact(0, 2'b01, 1, 32'h10, 0, g);
    total++; if (g !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_10 got %h want 0000beef", g); end
    xact(0, 2'b01, 0, 32'h12, 0, g);
    total++; if (g !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh_12 got %h want ffffdead", g); end
    xact(1, 2'b00, 0, 32'h11, 32'h55, g);
    xact(0, 2'b11, 0, 32'h10, 0, g);
    total++; if (g !== 32'hDEAD55EF) begin bad++; $display("FAIL lw_after_sb got %h want dead55ef", g); end
  endtask

  task automatic test_stall;
    exp_t x;
    logic [31:0] g;
    int n;
    push_exp(0, 2'b10, 0, 32'h10, 0);
    drive_req(0, 2'b10, 0, 32'h10, 0);
    rsp_ready = 0;
    @(posedge clk); #1;
    scramble();
    n = 0;
    while (!rv && n < 40) begin @(posedge clk); #1; n++; end
    x = q.pop_front();
    drive_req(1, 2'b10, 0, 32'h10, 32'h01020304);
    for (int c = 0; c < 5; c++) begin
      total += 3;
      if (rv !== 1'b1) begin bad++; $display("FAIL stall_valid cycle=%0d got %b want 1", c, rv); end
      if (rd !== x.d) begin bad++; $display("FAIL stall_rdata cycle=%0d got %h want %h", c, rd, x.d); end
      if (rdy !== 1'b0) begin bad++; $display("FAIL stall_req_ready cycle=%0d got %b want 0", c, rdy); end
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    total += 2;
    if (rv !== 1'b0) begin bad++; $display("FAIL stall_release_valid got %b want 0", rv); end
    if (rdy !== 1'b1) begin bad++; $display("FAIL no_bypass_req_ready got %b want 1", rdy); end
    scramble();
    @(posedge clk); #1;
    xact(0, 2'b10, 0, 32'h10, 0, g);
    total++; if (g !== 32'hDEAD55EF) begin bad++; $display("FAIL ignored_store got %h want dead55ef", g); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] g;
    xact(1, 2'b10, 0, 32'h20, 32'h11223344, g);
    drive_req(1, 2'b10, 0, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    total += 4;
    if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got %b want 0", a_rsp_valid); end
    if (a_rsp_rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata got %h want 0", a_rsp_rdata); end
    if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL abort_err got %b want 0", a_rsp_err); end
    if (a_req_ready !== 1'b1) begin bad++; $display("FAIL abort_req_ready got %b want 1", a_req_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    xact(0, 2'b10, 0, 32'h20, 0, g);
    total++; if (g !== 32'h11223344) begin bad++; $display("FAIL abort_no_write got %h want 11223344", g); end
  endtask

  task automatic test_misalign;
    logic [31:0] g, w;
    xact(1, 2'b10, 0, 32'h22, 32'hCAFEF00D, g);
    xact(0, 2'b10, 0, 32'h20, 0, g);
`ifdef DMEM_MISALIGN_ERR_EN
    w = 32'h11223344;
`else
    w = 32'hCAFEF00D;
`endif
    total++; if (g !== w) begin bad++; $display("FAIL misalign_store got %h want %h", g, w); end
    xact(0, 2'b01, 1, 32'h23, 0, g);
    xact(0, 2'b00, 1, 32'h23, 0, g);
  endtask

  task automatic test_back_to_back;
    logic [31:0] g;
    for (int i = 0; i < 8; i++) xact(1, 2'b10, 0, 32'h100 + 32'(4 * i), $urandom, g);
    for (int i = 0; i < 10; i++) xact(0, 2'($urandom), 1'($urandom), 32'h100 + 32'($urandom_range(31)), 0, g);
  endtask

  task automatic test_wait0;
    logic [31:0] g;
    sel = 1;
    xact(1, 2'b10, 0, 32'h010, 32'hA5A51234, g);
    xact(0, 2'b10, 0, 32'h1010, 0, g);
    total++; if (g !== 32'hA5A51234) begin bad++; $display("FAIL alias_lw got %h want a5a51234", g); end
    xact(0, 2'b00, 1, 32'h1013, 0, g);
    total++; if (g !== 32'h000000A5) begin bad++; $display("FAIL alias_lbu got %h want 000000a5", g); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_stall();
    test_reset_abort();
    test_misalign();
    test_back_to_back();
    test_wait0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
